// File: rtl/byte_serial_add32_if.sv
// Operand/result handshake bundle for byte_serial_add32.
// Master drives operands and out_ready; slave returns results.
interface byte_serial_add32_if #(
  parameter int N_BYTES = 4
);
  localparam int W = 8 * N_BYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/byte_serial_add32.sv
// Byte-serial wide adder: one shared 8-bit Han-Carlson
// prefix adder processes one byte slice per clock.
module hcadd8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [7:0] g, p;
  logic g0c;
  logic g10, g32, p32, g54, p54, g76, p76;
  logic g30, g52, p52, g74, p74;
  logic g50, g70;
  logic g20, g40, g60;

  assign g = a & b;
  assign p = a ^ b;
  // bit 0 absorbs the carry-in as its generate
  assign g0c = g[0] | (p[0] & ci);

  // odd-column prefix tree
  assign g10 = g[1] | (p[1] & g0c);
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g54 = g[5] | (p[5] & g[4]);
  assign p54 = p[5] & p[4];
  assign g76 = g[7] | (p[7] & g[6]);
  assign p76 = p[7] & p[6];

  assign g30 = g32 | (p32 & g10);
  assign g52 = g54 | (p54 & g32);
  assign p52 = p54 & p32;
  assign g74 = g76 | (p76 & g54);
  assign p74 = p76 & p54;

  assign g50 = g52 | (p52 & g10);
  assign g70 = g74 | (p74 & g30);

  // even columns fixed up from odd neighbours
  assign g20 = g[2] | (p[2] & g10);
  assign g40 = g[4] | (p[4] & g30);
  assign g60 = g[6] | (p[6] & g50);

  assign s = p ^ {g60, g50, g40, g30,
                  g20, g10, g0c, ci};
  assign co = g70;
endmodule

module byte_serial_add32 #(
  parameter int N_BYTES = 4
) (
  input logic clk,
  input logic rst_n,
  byte_serial_add32_if.slave bus
);
  localparam int W  = 8 * N_BYTES;
  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  a_reg, b_reg, sum_q;
  logic          carry_reg, cout_q, ovf_q, vld_q;
  logic [IW-1:0] idx;
  logic [7:0]    sa, sb, s;
  logic          sc, last, accept, release_q;

  assign last      = (idx == LAST);
  assign accept    = (state == IDLE) && bus.in_valid;
  assign release_q = (state == DONE) && bus.out_ready;

  // pick the current byte slice of each operand
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      if (idx == IW'(i)) begin
        sa = a_reg[8*i +: 8];
        sb = b_reg[8*i +: 8];
      end
    end
  end

  hcadd8 u_add (
    .a  (sa),
    .b  (sb),
    .ci (carry_reg),
    .s  (s),
    .co (sc)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept)    state_n = RUN;
      RUN:  if (last)      state_n = DONE;
      DONE: if (release_q) state_n = IDLE;
      default:             state_n = IDLE;
    endcase
  end

  // operand capture, slice walk and result assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            idx       <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < N_BYTES; i++) begin
            if (idx == IW'(i)) sum_q[8*i +: 8] <= s;
          end
          carry_reg <= sc;
          if (last) begin
            cout_q <= sc;
            ovf_q  <= sc ^ (a_reg[W-1] ^ b_reg[W-1] ^ s[7]);
            vld_q  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (release_q) vld_q <= 1'b0;
        end
        default: vld_q <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = vld_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_byte_serial_add32.sv
// Bench for byte_serial_add32: 4-byte and 1-byte builds
// driven side by side with a queue-based scoreboard.
module tb_byte_serial_add32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  byte_serial_add32_if #(.N_BYTES(4)) b4 ();
  byte_serial_add32_if #(.N_BYTES(1)) b1 ();

  byte_serial_add32 #(.N_BYTES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  byte_serial_add32 #(.N_BYTES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [33:0] q4[$];
  logic [9:0]  q1[$];

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, obs, exp);
  endtask

  // {ovf, cout, sum}
  function automatic logic [33:0] model4(
    logic [31:0] a, logic [31:0] b, logic ci);
    logic [32:0] t;
    logic ov;
    t  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    ov = (a[31] == b[31]) && (t[31] != a[31]);
    return {ov, t};
  endfunction

  function automatic logic [9:0] model1(
    logic [7:0] a, logic [7:0] b, logic ci);
    logic [8:0] t;
    logic ov;
    t  = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    ov = (a[7] == b[7]) && (t[7] != a[7]);
    return {ov, t};
  endfunction

  task automatic op4(logic [31:0] a, logic [31:0] b,
                     logic ci, int hold);
    int cyc;
    logic [33:0] e;
    @(negedge clk);
    check("rdy4", 64'(b4.in_ready), 64'd1);
    b4.in_valid = 1'b1;
    b4.a = a;
    b4.b = b;
    b4.cin = ci;
    q4.push_back(model4(a, b, ci));
    @(posedge clk);
    #1;
    b4.in_valid = 1'b0;
    b4.a = $urandom;
    b4.b = $urandom;
    cyc = 0;
    while (!b4.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("lat4", 64'(cyc), 64'd4);
    e = q4.pop_front();
    for (int k = 0; k < hold; k++) begin
      b4.in_valid = 1'b1;
      b4.a = $urandom;
      b4.b = $urandom;
      b4.cin = 1'($urandom);
      @(posedge clk);
      #1;
      check("bp_rdy4", 64'(b4.in_ready), 64'd0);
      check("bp_vld4", 64'(b4.out_valid), 64'd1);
      check("bp_sum4", 64'(b4.sum), 64'(e[31:0]));
    end
    check("sum4", 64'(b4.sum), 64'(e[31:0]));
    check("cout4", 64'(b4.cout), 64'(e[32]));
    check("ovf4", 64'(b4.ovf), 64'(e[33]));
    b4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b4.out_ready = 1'b0;
    b4.in_valid = 1'b0;
    check("rdy_after4", 64'(b4.in_ready), 64'd1);
    check("vld_after4", 64'(b4.out_valid), 64'd0);
  endtask

  task automatic op1(logic [7:0] a, logic [7:0] b,
                     logic ci);
    int cyc;
    logic [9:0] e;
    @(negedge clk);
    check("rdy1", 64'(b1.in_ready), 64'd1);
    b1.in_valid = 1'b1;
    b1.a = a;
    b1.b = b;
    b1.cin = ci;
    q1.push_back(model1(a, b, ci));
    @(posedge clk);
    #1;
    b1.in_valid = 1'b0;
    cyc = 0;
    while (!b1.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("lat1", 64'(cyc), 64'd1);
    e = q1.pop_front();
    check("sum1", 64'(b1.sum), 64'(e[7:0]));
    check("cout1", 64'(b1.cout), 64'(e[8]));
    check("ovf1", 64'(b1.ovf), 64'(e[9]));
    b1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b1.out_ready = 1'b0;
    check("rdy_after1", 64'(b1.in_ready), 64'd1);
  endtask

  initial begin
    b4.in_valid = 1'b0;
    b4.a = '0;
    b4.b = '0;
    b4.cin = 1'b0;
    b4.out_ready = 1'b0;
    b1.in_valid = 1'b0;
    b1.a = '0;
    b1.b = '0;
    b1.cin = 1'b0;
    b1.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_rdy", 64'(b4.in_ready), 64'd1);
    check("rst_vld", 64'(b4.out_valid), 64'd0);
    check("rst_sum", 64'(b4.sum), 64'd0);
    check("rst_cout", 64'(b4.cout), 64'd0);
    check("rst_ovf", 64'(b4.ovf), 64'd0);
    check("rst_vld1", 64'(b1.out_valid), 64'd0);
    rst_n = 1'b1;

    op4(32'h12345678, 32'h9ABCDEF0, 1'b0, 0);
    op4(32'hFFFFFFFF, 32'h00000000, 1'b1, 0);
    op4(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
    op4(32'h80000000, 32'h80000000, 1'b0, 0);
    op4(32'h0F0F0F0F, 32'h01010101, 1'b1, 5);

    // abort mid-RUN at idx == 2
    @(negedge clk);
    b4.in_valid = 1'b1;
    b4.a = 32'hFFFFFFFF;
    b4.b = 32'h11111111;
    b4.cin = 1'b1;
    @(posedge clk);
    #1;
    b4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_vld", 64'(b4.out_valid), 64'd0);
    check("abort_sum", 64'(b4.sum), 64'd0);
    check("abort_rdy", 64'(b4.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    op4(32'h00000001, 32'h00000002, 1'b0, 0);

    op1(8'hA3, 8'hAF, 1'b0);
    op1(8'h7F, 8'h00, 1'b1);
    op1(8'hFF, 8'hFF, 1'b1);

    for (int i = 0; i < 8; i++) begin
      op4($urandom, $urandom, 1'($urandom),
          int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 4; i++) begin
      op1(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
